// File: rtl/reg_dest_pkg.sv
// Shared definitions for the register-destination select stage:
// code classes, the fixed constant table and its code range.
package reg_dest_pkg;

  localparam int unsigned SEL_PASS  = 0;
  localparam int unsigned SEL_MAX   = 11;
  localparam int unsigned NUM_CONST = 11;

  typedef enum logic [1:0] {
    SEL_K_PASS,
    SEL_K_CONST,
    SEL_K_ERR
  } sel_kind_t;

  function automatic sel_kind_t sel_kind(input int unsigned code);
    if (code == SEL_PASS)
      return SEL_K_PASS;
    else if (code <= SEL_MAX)
      return SEL_K_CONST;
    else
      return SEL_K_ERR;
  endfunction

  // Table entry for code 1..NUM_CONST; anything else reads as zero.
  function automatic logic [15:0] const_val(input int unsigned code);
    logic [15:0] v;
    case (code)
      1:       v = 16'd0;
      2:       v = 16'd1;
      3:       v = 16'd2;
      4:       v = 16'd3;
      5:       v = 16'd4;
      6:       v = 16'd6;
      7:       v = 16'd7;
      8:       v = 16'd8;
      9:       v = 16'd9;
      10:      v = 16'd15;
      11:      v = 16'd5;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/reg_dest_sel_stage_skid_buffer.sv
// Generic 2-entry valid/ready register slice: a main output register
// plus one skid register that absorbs a beat accepted during a stall.
module skid_buffer #(
  parameter int unsigned W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         accept;
  logic         emit;

  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_q;
  assign accept    = in_valid & in_ready;
  assign emit      = main_valid_q & out_ready;

  // Skid only fills when main is full and not draining, so while it is
  // occupied in_ready is low and the only legal move is skid -> main.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (skid_valid_q) begin
      if (emit) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q || emit) begin
        main_d       = in_data;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = in_data;
        skid_valid_d = 1'b1;
      end
    end else if (emit) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

endmodule

// File: rtl/reg_dest_sel_stage.sv
// Pipelined register-destination select: resolves a selection code to the
// pass-through word or a table constant, flags and counts illegal codes.
module reg_dest_sel_stage
  import reg_dest_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SEL_W  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [DATA_W-1:0] Input,
  input  logic [SEL_W-1:0]  Selection,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] Output,
  output logic              Out_SelErr,
  output logic              Sel_Error,
  output logic [CNT_W-1:0]  Err_Count,
  input  logic              Err_Clr
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } payload_t;

  payload_t   sel_res;
  payload_t   out_res;
  sel_kind_t  kind;
  logic       accept_err;

  logic             sel_error_q, sel_error_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    kind    = sel_kind(32'(Selection));
    sel_res = '0;
    unique case (kind)
      SEL_K_PASS:  sel_res.data = Input;
      SEL_K_CONST: sel_res.data = DATA_W'(const_val(32'(Selection)));
      SEL_K_ERR:   sel_res.err  = 1'b1;
      default:     sel_res      = '0;
    endcase
  end

  skid_buffer #(
    .W($bits(payload_t))
  ) u_skid (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .in_valid (In_Valid),
    .in_ready (In_Ready),
    .in_data  (sel_res),
    .out_valid(Out_Valid),
    .out_ready(Out_Ready),
    .out_data (out_res)
  );

  assign Output     = out_res.data;
  assign Out_SelErr = out_res.err;
  assign accept_err = In_Valid & In_Ready & sel_res.err;

  // Clear is applied before the increment so a same-cycle error counts as one.
  always_comb begin
    sel_error_d = Err_Clr ? 1'b0 : sel_error_q;
    err_cnt_d   = Err_Clr ? '0 : err_cnt_q;
    if (accept_err) begin
      sel_error_d = 1'b1;
      if (err_cnt_d != '1)
        err_cnt_d = err_cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sel_error_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      sel_error_q <= sel_error_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign Sel_Error = sel_error_q;
  assign Err_Count = err_cnt_q;

endmodule

// File: tb/tb_reg_dest_sel_stage.sv
// Scoreboard bench for reg_dest_sel_stage: accepted beats are queued with
// their expected result and checked in order as the stage emits them.
module tb_reg_dest_sel_stage;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        In_Valid;
  logic        In_Ready;
  logic [15:0] Input;
  logic [3:0]  Selection;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [15:0] Output;
  logic        Out_SelErr;
  logic        Sel_Error;
  logic [7:0]  Err_Count;
  logic        Err_Clr;

  reg_dest_sel_stage #(
    .DATA_W(16),
    .SEL_W (4),
    .CNT_W (8)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Input     (Input),
    .Selection (Selection),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Output    (Output),
    .Out_SelErr(Out_SelErr),
    .Sel_Error (Sel_Error),
    .Err_Count (Err_Count),
    .Err_Clr   (Err_Clr)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  exp_t        q[$];
  int unsigned m_cnt    = 0;
  logic        m_sticky = 1'b0;
  int unsigned tbl[11]  = '{0, 1, 2, 3, 4, 6, 7, 8, 9, 15, 5};

  function automatic exp_t ref_model(input int unsigned code, input logic [15:0] d);
    exp_t e;
    e.err  = 1'b0;
    e.data = 16'h0;
    if (code == 0)       e.data = d;
    else if (code <= 11) e.data = 16'(tbl[code-1]);
    else                 e.err  = 1'b1;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: occupancy, error state, stall stability and ordered results.
  logic        hold_v = 1'b0;
  logic [15:0] hold_d;
  logic        hold_e;
  always @(negedge Clk) begin
    exp_t e;
    if (!Rst_n) begin
      hold_v = 1'b0;
    end else begin
      chk("in_ready", 32'(In_Ready), 32'(q.size() < 2));
      chk("out_valid", 32'(Out_Valid), 32'(q.size() > 0));
      chk("sel_error", 32'(Sel_Error), 32'(m_sticky));
      chk("err_count", 32'(Err_Count), m_cnt);
      if (hold_v && Out_Valid) begin
        chk("stall_output", 32'(Output), 32'(hold_d));
        chk("stall_selerr", 32'(Out_SelErr), 32'(hold_e));
      end
      hold_v = Out_Valid && !Out_Ready;
      hold_d = Output;
      hold_e = Out_SelErr;
      if (Out_Valid && Out_Ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got output %0h expected no beat", Output);
        end else begin
          e = q.pop_front();
          chk("output", 32'(Output), 32'(e.data));
          chk("out_selerr", 32'(Out_SelErr), 32'(e.err));
        end
      end
    end
  end

  task automatic drive(input logic v, input int unsigned sel, input logic [15:0] d,
                       input logic ordy, input logic clr);
    In_Valid  = v;
    Selection = 4'(sel);
    Input     = d;
    Out_Ready = ordy;
    Err_Clr   = clr;
  endtask

  // Records what the upcoming edge will accept, then advances one cycle.
  task automatic step();
    @(negedge Clk);
    #1;
    if (Rst_n) begin
      if (Err_Clr) begin
        m_sticky = 1'b0;
        m_cnt    = 0;
      end
      if (In_Valid && In_Ready) begin
        q.push_back(ref_model(32'(Selection), Input));
        if (Selection >= 12) begin
          m_sticky = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
      end
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst_n = 1'b0;
    drive(0, 0, 16'h0, 0, 0);
    #3;
    chk("rst_out_valid", 32'(Out_Valid), 0);
    chk("rst_output", 32'(Output), 0);
    chk("rst_out_selerr", 32'(Out_SelErr), 0);
    chk("rst_sel_error", 32'(Sel_Error), 0);
    chk("rst_err_count", 32'(Err_Count), 0);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    chk("rel_in_ready", 32'(In_Ready), 1);

    // All legal codes back-to-back at full rate.
    for (int c = 0; c < 12; c++) begin
      drive(1, c, 16'hBEEF, 1, 0);
      step();
    end
    drive(0, 0, 16'h0, 1, 0);
    step();
    step();

    // Illegal code, then a pass-through.
    drive(1, 13, 16'hFFFF, 1, 0);
    step();
    drive(1, 0, 16'h1234, 1, 0);
    step();
    drive(0, 0, 16'h0, 1, 0);
    step();
    chk("err13_sticky", 32'(Sel_Error), 1);
    chk("err13_count", 32'(Err_Count), 1);
    step();

    // Stall with three offers: third must be refused until a slot frees.
    drive(1, 2, 16'h0, 0, 0);
    step();
    drive(1, 3, 16'h0, 0, 0);
    step();
    drive(1, 4, 16'h0, 0, 0);
    chk("stall_in_ready_low", 32'(In_Ready), 0);
    step();
    step();
    chk("stall_in_ready_held", 32'(In_Ready), 0);
    chk("stall_output_one", 32'(Output), 1);
    drive(1, 4, 16'h0, 1, 0);
    step();
    step();
    drive(0, 0, 16'h0, 1, 0);
    for (int i = 0; i < 4; i++) step();

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++) begin
      drive(1, $urandom_range(15, 12), 16'($urandom), 1, 0);
      step();
    end
    drive(0, 0, 16'h0, 1, 0);
    step();
    step();
    chk("sat_count", 32'(Err_Count), 255);
    chk("sat_sticky", 32'(Sel_Error), 1);

    // Clear coinciding with an error, then clear alone.
    drive(1, 14, 16'h0, 1, 1);
    step();
    chk("clr_err_count", 32'(Err_Count), 1);
    chk("clr_err_sticky", 32'(Sel_Error), 1);
    drive(0, 0, 16'h0, 1, 1);
    step();
    chk("clr_count", 32'(Err_Count), 0);
    chk("clr_sticky", 32'(Sel_Error), 0);
    drive(0, 0, 16'h0, 1, 0);
    step();

    // Random traffic with back-pressure and occasional clears.
    for (int i = 0; i < 500; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 15), 16'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
      step();
    end
    drive(0, 0, 16'h0, 1, 0);
    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", q.size());
    end
    step();

    // Fill main and skid, then assert reset mid-cycle.
    drive(1, 15, 16'h0, 0, 0);
    step();
    drive(1, 3, 16'h0, 0, 0);
    step();
    chk("full_in_ready", 32'(In_Ready), 0);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(Out_Valid), 0);
    chk("arst_output", 32'(Output), 0);
    chk("arst_out_selerr", 32'(Out_SelErr), 0);
    chk("arst_err_count", 32'(Err_Count), 0);
    chk("arst_sel_error", 32'(Sel_Error), 0);
    q.delete();
    m_cnt    = 0;
    m_sticky = 1'b0;
    drive(0, 0, 16'h0, 1, 0);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    chk("arst_rel_in_ready", 32'(In_Ready), 1);
    for (int i = 0; i < 3; i++) step();
    chk("arst_no_stale", 32'(Out_Valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
